// File: rtl/gauss_weight_sampler.sv
// Samples one BNN weight per (mu, sigma) request: w = sat8(mu + ((sigma*eps) >>> SHIFT)), eps from a small FIFO.
// Define GWS_ROUND_EN to round the shifted product half up instead of flooring it.
module gauss_weight_sampler #(
  parameter int SHIFT   = 8,
  parameter int FIFO_AW = 2
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               flush,
  input  logic signed [15:0] eps_in,
  input  logic               eps_valid,
  output logic               eps_ovf,
  input  logic               ivalid,
  output logic               oready,
  input  logic signed [7:0]  mu,
  input  logic [7:0]         sigma,
  output logic               ovalid,
  input  logic               iready,
  output logic signed [7:0]  w_out,
  output logic [15:0]        sat_cnt
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(DEPTH);

  logic signed [15:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               empty, full, stall, accept, push, drop;
  logic signed [15:0] eps_head;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign stall    = ovalid & ~iready;
  assign oready   = ~stall & ~empty & ~flush;
  assign accept   = ivalid & oready;
  // A full FIFO can still take a sample when the same cycle pops one.
  assign push     = eps_valid & (~full | accept);
  assign drop     = eps_valid & full & ~accept;
  assign eps_head = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= eps_in;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      eps_ovf <= 1'b0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      eps_ovf <= 1'b0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (accept) rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push, accept})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: count <= count;
      endcase
      if (drop) eps_ovf <= 1'b1;
    end
  end

  // Stage 1: sigma is unsigned, so it is zero-extended before the signed multiply.
  logic signed [24:0] sig_ext, eps_ext, prod_c, prod_r;
  logic signed [7:0]  mu_r;
  logic               s1_valid;

  assign sig_ext = {17'd0, sigma};
  assign eps_ext = {{9{eps_head[15]}}, eps_head};
  assign prod_c  = sig_ext * eps_ext;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      prod_r   <= '0;
      mu_r     <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid <= accept;
      if (accept) begin
        prod_r <= prod_c;
        mu_r   <= mu;
      end
    end
  end

  // Stage 2: shift, add mean and clamp to the fix8 range.
  logic signed [25:0] prod_ext, sh, sum;
  logic               sat_hi, sat_lo;
  logic signed [7:0]  w_c;

  assign prod_ext = {prod_r[24], prod_r};
`ifdef GWS_ROUND_EN
  localparam logic signed [25:0] RND = 26'sd1 <<< (SHIFT-1);
  assign sh = (prod_ext + RND) >>> SHIFT;
`else
  assign sh = prod_ext >>> SHIFT;
`endif
  assign sum    = {{18{mu_r[7]}}, mu_r} + sh;
  assign sat_hi = (sum > 26'sd127);
  assign sat_lo = (sum < -26'sd128);
  assign w_c    = sat_hi ? 8'h7F : (sat_lo ? 8'h80 : sum[7:0]);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ovalid  <= 1'b0;
      w_out   <= '0;
      sat_cnt <= '0;
    end else if (flush) begin
      ovalid  <= 1'b0;
      w_out   <= '0;
      sat_cnt <= '0;
    end else if (!stall) begin
      ovalid <= s1_valid;
      w_out  <= w_c;
      if (s1_valid && (sat_hi || sat_lo) && (sat_cnt != 16'hFFFF))
        sat_cnt <= sat_cnt + 16'd1;
    end
  end

endmodule
